// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: initiator for the single RW port of an OpenRAM SRAM macro.
// Requests are registered straight onto the macro pins (stage A). Read data is
// captured two edges after issue (stage B) into a small in-order response
// FIFO. Request acceptance is throttled so the FIFO can never overflow.
module sram_port_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned RSP_DEPTH  = 4
) (
   input  logic                  clk0,
   input  logic                  rst0_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  idle
);

   localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int unsigned INF_W = CNT_W + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

   logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_count;
   logic                  rd_a;
   logic                  rd_b;
   logic [INF_W-1:0]      inflight;
   logic                  accept;
   logic                  push;
   logic                  pop;

   // Wrapping pointer increment; works for non-power-of-two depths too.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Every accepted read holds a FIFO slot from issue until it is popped.
   assign inflight  = INF_W'(rd_a) + INF_W'(rd_b) + INF_W'(fifo_count);
   assign req_ready = (inflight < INF_W'(RSP_DEPTH));
   assign accept    = req_valid && req_ready;
   assign push      = rd_b;
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_valid = (fifo_count != '0);
   assign rsp_rdata = fifo_mem[rd_ptr];
   assign idle      = ~rd_a & ~rd_b & (fifo_count == '0);

   // Stage A: drive the macro pins; chip-select is only asserted for one
   // cycle per accepted request. din0 keeps its last write value on reads.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         sram_csb0  <= 1'b1;
         sram_web0  <= 1'b1;
         sram_addr0 <= '0;
         sram_din0  <= '0;
         rd_a       <= 1'b0;
      end else if (accept) begin
         sram_csb0  <= 1'b0;
         sram_web0  <= ~req_we;
         sram_addr0 <= req_addr;
         if (req_we) begin
            sram_din0 <= req_wdata;
         end
         rd_a       <= ~req_we;
      end else begin
         sram_csb0  <= 1'b1;
         sram_web0  <= 1'b1;
         rd_a       <= 1'b0;
      end
   end

   // Stage B: the macro samples the pins this cycle; data is valid next edge.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         rd_b <= 1'b0;
      end else begin
         rd_b <= rd_a;
      end
   end

   // Response FIFO pointers and occupancy.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Response FIFO storage; dout0 is only sampled when a read is due.
   always_ff @(posedge clk0) begin
      if (push) begin
         fifo_mem[wr_ptr] <= sram_dout0;
      end
   end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: drives sram_port_ctrl against a behavioural OpenRAM-style
// macro and compares every cycle with a transaction-level reference model.
module tb_sram_port_ctrl;

   localparam int unsigned DW        = 8;
   localparam int unsigned AW        = 9;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned RAM_WORDS = 1 << AW;

   logic          clk0 = 1'b0;
   logic          rst0_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          sram_csb0;
   logic          sram_web0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0;
   logic [DW-1:0] sram_dout0;
   logic          idle;

   sram_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
      .clk0       (clk0),
      .rst0_n     (rst0_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0),
      .idle       (idle)
   );

   always #5 clk0 = ~clk0;

   // Macro model: latch pins on posedge, write or read on the following negedge.
   logic [DW-1:0] sram_mem [RAM_WORDS];
   logic          s_csb = 1'b1;
   logic          s_web = 1'b1;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_din;

   always @(posedge clk0) begin
      s_csb  <= sram_csb0;
      s_web  <= sram_web0;
      s_addr <= sram_addr0;
      s_din  <= sram_din0;
   end

   always @(negedge clk0) begin
      if (!s_csb && !s_web) begin
         sram_mem[s_addr] = s_din;
         sram_dout0 = 'x;
      end else if (!s_csb) begin
         sram_dout0 = sram_mem[s_addr];
      end else begin
         sram_dout0 = 'x;
      end
   end

   // Reference model: memory image, queue of outstanding reads with the cycle
   // at which each becomes visible, and the expected pin state.
   typedef struct {
      logic [DW-1:0] data;
      int            ready_cyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] ref_mem [RAM_WORDS];
   logic          exp_csb;
   logic          exp_web;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_din;
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic head_visible();
      return (exp_q.size() > 0) && (exp_q[0].ready_cyc <= cyc);
   endfunction

   task automatic check_outputs();
      logic ev;
      ev = head_visible();
      check_eq("csb0", 32'(sram_csb0), 32'(exp_csb));
      check_eq("web0", 32'(sram_web0), 32'(exp_web));
      check_eq("addr0", 32'(sram_addr0), 32'(exp_addr));
      check_eq("din0", 32'(sram_din0), 32'(exp_din));
      check_eq("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
      check_eq("idle", 32'(idle), 32'(exp_q.size() == 0));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
         check_eq("rdata_known", 32'($isunknown(rsp_rdata)), 32'(0));
         check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].data));
      end
   endtask

   // One clock cycle, entered and left at a negedge.
   task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
      logic acc;
      logic pop;
      check_outputs();
      acc = v && (exp_q.size() < DEPTH);
      pop = head_visible() && rr;
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      rsp_ready = rr;
      @(posedge clk0);
      cyc++;
      if (pop) begin
         void'(exp_q.pop_front());
      end
      if (acc) begin
         exp_csb  = 1'b0;
         exp_web  = ~we;
         exp_addr = a;
         if (we) begin
            exp_din    = d;
            ref_mem[a] = d;
         end else begin
            exp_q.push_back('{ref_mem[a], cyc + 2});
         end
      end else begin
         exp_csb = 1'b1;
         exp_web = 1'b1;
      end
      @(negedge clk0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_csb  = 1'b1;
      exp_web  = 1'b1;
      exp_addr = '0;
      exp_din  = '0;
   endtask

   initial begin
      rst0_n    = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      model_reset();

      // Reset values, then release away from the clock edge.
      repeat (2) @(negedge clk0);
      check_outputs();
      rst0_n = 1'b1;

      // Fill the whole macro with a known image.
      for (int i = 0; i < int'(RAM_WORDS); i++) begin
         step(1'b1, 1'b1, AW'(i), DW'(i * 7 + 3), 1'b1);
      end
      step(1'b0, 1'b0, '0, '0, 1'b1);

      // Asynchronous reset with a read between issue and capture.
      step(1'b1, 1'b0, AW'(9'h005), '0, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b1);
      #2 rst0_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk0);
      rst0_n = 1'b1;
      repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1);

      // Write then read-after-write on the next cycle.
      step(1'b1, 1'b1, AW'(9'h003), 8'h5A, 1'b1);
      step(1'b1, 1'b0, AW'(9'h003), '0, 1'b1);
      repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1);

      // Preload and back-to-back burst of reads.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, AW'(i), DW'(8'h10 + i), 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, AW'(i), '0, 1'b1);
      repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1);

      // Backpressure: responses blocked while reads keep streaming.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, AW'(i + 2), '0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, AW'(i), '0, 1'b1);
      repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1);

      // Address extremes and FIFO pointer wrap under toggling rsp_ready.
      step(1'b1, 1'b1, AW'(9'h1FF), 8'hFF, 1'b1);
      step(1'b1, 1'b1, AW'(9'h000), 8'h01, 1'b1);
      step(1'b1, 1'b0, AW'(9'h1FF), '0, 1'b1);
      step(1'b1, 1'b0, AW'(9'h000), '0, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, AW'(i * 37), '0, 1'(i));
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, '0, 1'(i));

      // Request gaps: valid toggling with a read/write mix.
      for (int i = 0; i < 16; i++) begin
         step(1'(i), 1'(i >> 2), AW'(i + 20), DW'(i * 11), 1'b1);
      end

      // Randomised traffic, biased towards a small hot region for RAW hits.
      for (int i = 0; i < 600; i++) begin
         logic          v;
         logic          we;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         logic          rr;
         v  = 1'($urandom_range(0, 3) != 0);
         we = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                          : AW'($urandom_range(0, RAM_WORDS - 1));
         d  = DW'($urandom);
         rr = 1'($urandom_range(0, 3) != 0);
         step(v, we, a, d, rr);
      end
      repeat (8) step(1'b0, 1'b0, '0, '0, 1'b1);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
